// File: rtl/enm_hit_ctrl_pkg.sv
// Shared constants, FSM state type and ring-index helper for the enemy
// hit-point controller.
package enm_pkg;
   localparam int NUM_ENM = 4;
   localparam int NUM_REQ = 3;
   localparam int HP_W    = 7;
   localparam int WAVE_W  = 4;
   localparam int HP_PH1  = 80;
   localparam int HP_PH2  = 40;

   typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

   // Folds 0..5 back onto the 0..2 requester ring.
   function automatic logic [1:0] rr_wrap(input logic [2:0] v);
      return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
   endfunction
endpackage

// File: rtl/enm_hit_ctrl_if.sv
// Hit request bus between the three requesters and the HP controller.
interface enm_hit_ctrl_if;
   import enm_pkg::*;

   logic [NUM_REQ-1:0]           hit_req;
   logic [NUM_REQ-1:0][1:0]      hit_id;
   logic [NUM_REQ-1:0][HP_W-1:0] hit_dmg;
   logic [NUM_REQ-1:0]           hit_ack;

   modport master (output hit_req, hit_id, hit_dmg, input hit_ack);
   modport slave  (input hit_req, hit_id, hit_dmg, output hit_ack);
endinterface

// File: rtl/enm_hit_ctrl_rr_arb3.sv
// Combinational 3-way round-robin arbiter; the pointer register is owned by
// the parent so it can be reset together with the rest of the controller.
module rr_arb3
   import enm_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt,
   output logic [1:0] ptr_nxt
);

   logic [1:0] idx;
   logic       found;

   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = '0;
      for (int k = 0; k < 3; k++) begin
         idx = rr_wrap({1'b0, ptr} + 3'(k));
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            ptr_nxt  = rr_wrap({1'b0, idx} + 3'd1);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/enm_hit_ctrl.sv
// Enemy HP controller: arbitrates hit requests, applies damage with
// per-enemy invulnerability and sequences waves with a respawn delay.
//
//   state | meaning
//   IDLE  | no wave running, HP held at 0, waiting for start
//   RUN   | wave active, acked hits apply damage
//   CLEAR | all enemies dead, counting respawn delay; hits are acked and dropped
module enm_hit_ctrl
   import enm_pkg::*;
#(
   parameter int HP_INIT     = 100,
   parameter int COOLDOWN    = 8,
   parameter int RESPAWN_DLY = 64
)(
   input  logic              clk22,
   input  logic              rst,
   input  logic              start,
   enm_hit_ctrl_if.slave     hit,
   output logic [HP_W-1:0]   enmhp1,
   output logic [HP_W-1:0]   enmhp2,
   output logic [HP_W-1:0]   enmhp3,
   output logic [HP_W-1:0]   enmhp4,
   output logic [WAVE_W-1:0] wave,
   output logic              all_dead,
   output logic              busy
);

   localparam int CD_W  = $clog2(COOLDOWN + 1);
   localparam int CNT_W = $clog2(RESPAWN_DLY + 1);

   localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HP_INIT);
   localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESPAWN_DLY - 1);

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       ptr_nxt;
   logic [2:0]       gnt;
   logic [1:0]       gidx;
   logic             gvld;
   logic [1:0]       tgt;
   logic [HP_W-1:0]  dmg;
   logic             accept;
   logic [HP_W-1:0]  hp [NUM_ENM];
   logic [CD_W-1:0]  cd [NUM_ENM];
   logic [CNT_W-1:0] dly_cnt;

   rr_arb3 u_arb (
      .req     (hit.hit_req),
      .ptr     (ptr),
      .gnt     (gnt),
      .ptr_nxt (ptr_nxt)
   );

   assign hit.hit_ack = gnt;

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gidx = 2'(i);
      end
   end

   assign gvld = |gnt;
   assign tgt  = hit.hit_id[gidx];
   assign dmg  = hit.hit_dmg[gidx];

   // Dead, cooling-down and zero-damage hits are acked but leave no trace.
   assign accept = (state == RUN) && gvld && (hp[tgt] != '0) &&
                   (cd[tgt] == '0) && (dmg != '0);

   assign all_dead = (hp[0] == '0) && (hp[1] == '0) &&
                     (hp[2] == '0) && (hp[3] == '0);

   assign enmhp1 = hp[0];
   assign enmhp2 = hp[1];
   assign enmhp3 = hp[2];
   assign enmhp4 = hp[3];

   always_ff @(posedge clk22) begin
      if (rst) begin
         state   <= IDLE;
         busy    <= 1'b0;
         ptr     <= '0;
         wave    <= '0;
         dly_cnt <= '0;
         for (int i = 0; i < NUM_ENM; i++) begin
            hp[i] <= '0;
            cd[i] <= '0;
         end
      end else begin
         ptr <= ptr_nxt;
         for (int i = 0; i < NUM_ENM; i++) begin
            if (cd[i] != '0) cd[i] <= cd[i] - 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < NUM_ENM; i++) begin
                     hp[i] <= HP_LOAD;
                     cd[i] <= '0;
                  end
                  wave  <= WAVE_W'(1);
                  state <= RUN;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               if (all_dead) begin
                  state   <= CLEAR;
                  busy    <= 1'b0;
                  dly_cnt <= '0;
               end else if (accept) begin
                  hp[tgt] <= (dmg >= hp[tgt]) ? '0 : hp[tgt] - dmg;
                  cd[tgt] <= CD_LOAD;
               end
            end
            CLEAR: begin
               if (dly_cnt == CNT_LAST) begin
                  for (int i = 0; i < NUM_ENM; i++) begin
                     hp[i] <= HP_LOAD;
                     cd[i] <= '0;
                  end
                  wave  <= wave + WAVE_W'(1);
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  dly_cnt <= dly_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_enm_hit_ctrl.sv
// Bench for enm_hit_ctrl: directed vector table, hand sequences for clear and
// mid-wave reset, then protocol-respecting random traffic against a cycle model.
module tb_enm_hit_ctrl;

   localparam int HP_INIT     = 100;
   localparam int COOLDOWN    = 8;
   localparam int RESPAWN_DLY = 64;

   logic       clk22 = 1'b0;
   logic       rst;
   logic       start;
   logic [6:0] enmhp1, enmhp2, enmhp3, enmhp4;
   logic [3:0] wave;
   logic       all_dead, busy;

   enm_hit_ctrl_if hif ();

   enm_hit_ctrl #(.HP_INIT(HP_INIT), .COOLDOWN(COOLDOWN), .RESPAWN_DLY(RESPAWN_DLY)) dut (
      .clk22    (clk22),
      .rst      (rst),
      .start    (start),
      .hit      (hif),
      .enmhp1   (enmhp1),
      .enmhp2   (enmhp2),
      .enmhp3   (enmhp3),
      .enmhp4   (enmhp4),
      .wave     (wave),
      .all_dead (all_dead),
      .busy     (busy)
   );

   always #5 clk22 = ~clk22;

   int errs   = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Reference model: HP values, absolute cycle until which each enemy is
   // immune, wave number, phase (0 idle, 1 running, 2 clearing).
   int m_hp [4];
   int m_imm [4];
   int m_ptr, m_wave, m_phase, m_cyc, m_clr0, m_g;

   typedef struct {
      logic        r;
      logic        s;
      logic [2:0]  req;
      logic [5:0]  id;
      logic [20:0] dmg;
      logic [2:0]  ack;
      int          hp1;
      int          wv;
      logic        bsy;
      logic        ad;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, m_cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_hp[i]  = 0;
         m_imm[i] = -1000;
      end
      m_ptr = 0; m_wave = 0; m_phase = 0;
   endtask

   task automatic model_load();
      for (int i = 0; i < 4; i++) begin
         m_hp[i]  = HP_INIT;
         m_imm[i] = -1000;
      end
      m_phase = 1;
   endtask

   task automatic model_predict();
      m_g = -1;
      for (int k = 0; k < 3; k++) begin
         if (m_g < 0 && hif.hit_req[(m_ptr + k) % 3]) m_g = (m_ptr + k) % 3;
      end
   endtask

   task automatic model_compare();
      int e_ack;
      bit dead;
      e_ack = (m_g >= 0) ? (1 << m_g) : 0;
      dead  = (m_hp[0] == 0) && (m_hp[1] == 0) && (m_hp[2] == 0) && (m_hp[3] == 0);
      chk("m_ack", int'(hif.hit_ack), e_ack);
      chk("m_hp1", int'(enmhp1), m_hp[0]);
      chk("m_hp2", int'(enmhp2), m_hp[1]);
      chk("m_hp3", int'(enmhp3), m_hp[2]);
      chk("m_hp4", int'(enmhp4), m_hp[3]);
      chk("m_wave", int'(wave), m_wave);
      chk("m_all_dead", int'(all_dead), int'(dead));
      chk("m_busy", int'(busy), int'(m_phase == 1));
   endtask

   task automatic model_advance();
      int e, d;
      bit dead;
      if (rst) begin
         model_reset();
      end else begin
         dead = (m_hp[0] == 0) && (m_hp[1] == 0) && (m_hp[2] == 0) && (m_hp[3] == 0);
         if (m_g >= 0) m_ptr = (m_g + 1) % 3;
         if (m_phase == 0) begin
            if (start) begin
               model_load();
               m_wave = 1;
            end
         end else if (m_phase == 1) begin
            if (dead) begin
               m_phase = 2;
               m_clr0  = m_cyc + 1;
            end else if (m_g >= 0) begin
               e = int'(hif.hit_id[m_g]);
               d = int'(hif.hit_dmg[m_g]);
               if (m_hp[e] > 0 && m_cyc > m_imm[e] && d > 0) begin
                  m_hp[e]  = (d >= m_hp[e]) ? 0 : m_hp[e] - d;
                  m_imm[e] = m_cyc + COOLDOWN;
               end
            end
         end else begin
            if (m_cyc == m_clr0 + RESPAWN_DLY - 1) begin
               model_load();
               m_wave = (m_wave + 1) % 16;
            end
         end
      end
      m_cyc++;
   endtask

   task automatic cyc(input logic r, input logic s, input logic [2:0] req,
                      input logic [5:0] id, input logic [20:0] dmg);
      @(negedge clk22);
      rst = r; start = s;
      hif.hit_req = req; hif.hit_id = id; hif.hit_dmg = dmg;
      model_predict();
      #1;
      if (chk_en) model_compare();
      model_advance();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 3'b000, 6'd0, 21'd0);
   endtask

   task automatic hit1(input int ri, input int e, input int d);
      logic [5:0]  id;
      logic [20:0] dm;
      id = '0; dm = '0;
      id[2*ri +: 2] = 2'(e);
      dm[7*ri +: 7] = 7'(d);
      cyc(1'b0, 1'b0, 3'(1 << ri), id, dm);
   endtask

   task automatic sv(input int i, input logic r, input logic s, input logic [2:0] req,
                     input logic [5:0] id, input logic [20:0] dmg, input logic [2:0] ack,
                     input int hp1, input int wv, input logic bsy, input logic ad);
      tbl[i] = '{r: r, s: s, req: req, id: id, dmg: dmg, ack: ack,
                 hp1: hp1, wv: wv, bsy: bsy, ad: ad};
   endtask

   logic [2:0]  rq;
   logic [1:0]  rid [3];
   logic [6:0]  rdm [3];
   logic [5:0]  vid;
   logic [20:0] vdm;
   int          last_g;
   int          sel;

   initial begin
      sv(0, 1, 0, 3'b000, 6'd0, 21'd0, 3'b000, 0, 0, 0, 1);
      sv(1, 0, 1, 3'b000, 6'd0, 21'd0, 3'b000, 0, 0, 0, 1);
      sv(2, 0, 0, 3'b000, 6'd0, 21'd0, 3'b000, 100, 1, 1, 0);
      sv(3, 0, 0, 3'b001, 6'd0, {14'd0, 7'd30}, 3'b001, 100, 1, 1, 0);
      sv(4, 0, 0, 3'b001, 6'd0, {14'd0, 7'd30}, 3'b001, 70, 1, 1, 0);
      for (int i = 5; i <= 11; i++) sv(i, 0, 0, 3'b000, 6'd0, 21'd0, 3'b000, 70, 1, 1, 0);
      sv(12, 0, 0, 3'b001, 6'd0, {14'd0, 7'd30}, 3'b001, 70, 1, 1, 0);
      sv(13, 0, 0, 3'b000, 6'd0, 21'd0, 3'b000, 40, 1, 1, 0);
      sv(14, 0, 0, 3'b100, {2'd3, 4'd0}, 21'd0, 3'b100, 40, 1, 1, 0);
      for (int i = 15; i <= 20; i++)
         sv(i, 0, 0, 3'b111, {2'd3, 2'd2, 2'd1}, 21'd0, 3'(1 << ((i - 15) % 3)), 40, 1, 1, 0);
      sv(21, 0, 0, 3'b000, 6'd0, 21'd0, 3'b000, 40, 1, 1, 0);

      rst = 1'b1; start = 1'b0;
      hif.hit_req = '0; hif.hit_id = '0; hif.hit_dmg = '0;
      m_cyc = 0; m_clr0 = 0; m_g = -1;
      model_reset();

      cyc(1'b1, 1'b0, 3'b000, 6'd0, 21'd0);
      chk_en = 1'b1;

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].req, tbl[i].id, tbl[i].dmg);
         chk($sformatf("t%0d_ack", i), int'(hif.hit_ack), int'(tbl[i].ack));
         chk($sformatf("t%0d_hp1", i), int'(enmhp1), tbl[i].hp1);
         chk($sformatf("t%0d_wave", i), int'(wave), tbl[i].wv);
         chk($sformatf("t%0d_busy", i), int'(busy), int'(tbl[i].bsy));
         chk($sformatf("t%0d_dead", i), int'(all_dead), int'(tbl[i].ad));
      end

      // Enemy 3 down to 15, then killed, then hit again while dead.
      hit1(1, 2, 85);
      chk("e3_ack85", int'(hif.hit_ack), 2);
      idle(8);
      chk("e3_hp15", int'(enmhp3), 15);
      hit1(1, 2, 40);
      chk("e3_ack40", int'(hif.hit_ack), 2);
      idle(1);
      chk("e3_hp0", int'(enmhp3), 0);
      idle(8);
      hit1(0, 2, 50);
      chk("e3_dead_ack", int'(hif.hit_ack), 1);
      idle(1);
      chk("e3_stays0", int'(enmhp3), 0);

      // Kill the rest, watch the clear delay and the respawn.
      hit1(0, 0, 127);
      hit1(1, 1, 127);
      hit1(2, 3, 127);
      idle(1);
      chk("kill_all_dead", int'(all_dead), 1);
      chk("kill_busy_run", int'(busy), 1);
      hit1(2, 0, 5);
      chk("clear_ack", int'(hif.hit_ack), 4);
      chk("clear_busy", int'(busy), 0);
      idle(63);
      chk("clear_last_busy", int'(busy), 0);
      chk("clear_last_hp1", int'(enmhp1), 0);
      idle(1);
      chk("resp_hp1", int'(enmhp1), 100);
      chk("resp_hp2", int'(enmhp2), 100);
      chk("resp_hp3", int'(enmhp3), 100);
      chk("resp_hp4", int'(enmhp4), 100);
      chk("resp_wave", int'(wave), 2);
      chk("resp_busy", int'(busy), 1);

      // Reset mid-wave with a live grant.
      cyc(1'b1, 1'b0, 3'b001, 6'd0, {14'd0, 7'd10});
      chk("rst_ack", int'(hif.hit_ack), 1);
      cyc(1'b0, 1'b0, 3'b001, 6'd0, {14'd0, 7'd10});
      chk("rst_hp1", int'(enmhp1), 0);
      chk("rst_wave", int'(wave), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_idle_ack", int'(hif.hit_ack), 1);
      idle(1);
      chk("rst_hp1_after", int'(enmhp1), 0);

      // Random requesters that hold each request until it is granted.
      rq = '0; last_g = -1;
      for (int i = 0; i < 3; i++) begin
         rid[i] = '0;
         rdm[i] = '0;
      end
      for (int n = 0; n < 4000; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (rq[i] && last_g == i) begin
               rq[i] = 1'b0;
            end else if (!rq[i] && $urandom_range(0, 2) == 0) begin
               rq[i]  = 1'b1;
               rid[i] = 2'($urandom_range(0, 3));
               sel    = $urandom_range(0, 3);
               rdm[i] = (sel == 0) ? 7'd0 :
                        (sel == 1) ? 7'($urandom_range(1, 20)) : 7'($urandom_range(20, 127));
            end
         end
         vid = {rid[2], rid[1], rid[0]};
         vdm = {rdm[2], rdm[1], rdm[0]};
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0), rq, vid, vdm);
         last_g = m_g;
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/enm_hit_ctrl.md
# enm_hit_ctrl

Enemy hit-point controller and wave sequencer. Shares the four enemy HP registers between three hit requesters (player bullets, bomb, contact) through a round-robin arbiter, applies damage with per-enemy invulnerability cooldown, and runs the wave state machine that respawns all enemies after a clear delay. Its `enmhp1..4` outputs drive the enemy movement block directly; HP thresholds 80/40/0 select the movement phases there.

## Interface
- `HP_INIT`, 100, HP loaded into each enemy at wave start (must be > 80, ≤ 127)
- `COOLDOWN`, 8, clk22 cycles an enemy ignores damage after a damaging hit
- `RESPAWN_DLY`, 64, clk22 cycles spent in CLEAR before the next wave loads
- `clk22` in 1: game tick clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `start` in 1: level; begins wave 1 from IDLE
- `hit_req` in 3: per-requester request; held high until acked
- `hit_id` in 3×2: target enemy per requester (0..3 → enemy 1..4); stable while req high
- `hit_dmg` in 3×7: damage per requester; stable while req high
- `hit_ack` out 3: one-hot grant, combinational from current req/pointer/state
- `enmhp1..enmhp4` out 7 each: current HP
- `wave` out 4: wave number
- `all_dead` out 1: high when all four HP are 0
- `busy` out 1: high in RUN

## Operation
- FSM states: IDLE, RUN, CLEAR.
  - IDLE: HP all 0. `start`=1 → load all HP to HP_INIT, `wave` := 1, clear cooldowns → RUN.
  - RUN: processes hits. When all four HP are 0 at a clock edge → CLEAR, delay counter := 0.
  - CLEAR: counter increments each cycle. At RESPAWN_DLY−1 → reload HP_INIT, `wave` := wave+1 (15 wraps to 0), clear cooldowns → RUN.
  - `start` is ignored outside IDLE.
- Arbiter:
  - Round-robin over the 3 requesters. Search starts at pointer `p`.
  - At most one ack per cycle. Pointer := granted index + 1 (mod 3); it is unchanged when nothing is granted.
  - Requests are acked in every state. In IDLE and CLEAR the ack consumes the request with no effect.
- Damage applied on the acked request:
  - Target HP = 0 (dead): no effect.
  - Target cooldown ≠ 0: no effect.
  - dmg = 0: no effect and no cooldown start.
  - Otherwise: HP := (dmg ≥ HP) ? 0 : HP − dmg, and cooldown := COOLDOWN.
- Cooldown counters decrement by 1 each cycle while nonzero, independently per enemy.

## Timing
- Reset values, applied at the same edge, including mid-wave:
  - HP all 0, `wave` 0, state IDLE, pointer 0, cooldowns 0, delay counter 0.
  - Outputs therefore reset to `busy` 0, `all_dead` 1, `hit_ack` 0 (no req).
- Hit latency:
  - Ack is asserted in cycle N.
  - The HP update is visible in cycle N+1.
  - The requester must drop or change `hit_req` after the edge that ends cycle N.
  - A requester still high in N+1 is treated as a new request.
- Cooldown:
  - Set at edge N. The enemy is immune to damage on acks in cycles N+1 … N+COOLDOWN.
  - Damage is accepted again in cycle N+COOLDOWN+1.
- All-dead / clear:
  - A hit that zeroes the last enemy at edge N gives `all_dead`=1 in N+1.
  - State is CLEAR in N+2; reload happens RESPAWN_DLY cycles later.
- Two requests for the same enemy in one cycle: only the granted one applies. The other is acked in a later cycle and then sees the cooldown.
- Arithmetic: 7-bit unsigned, saturating at 0, never wraps.

## Structure
- Package `enm_pkg`:
  - `NUM_ENM`=4, `NUM_REQ`=3, HP width 7, wave width 4.
  - Phase thresholds `HP_PH1`=80, `HP_PH2`=40.
  - FSM state enum `{IDLE, RUN, CLEAR}`.
- Sub-module `rr_arb3`: round-robin arbiter, inputs req[3] and pointer; outputs one-hot gnt and next pointer. Purely combinational; the pointer register lives in the parent.
- The HP, cooldown and FSM registers live in `enm_hit_ctrl`.

## Test plan
- Reset, then `start` pulse → next cycle HP = 100,100,100,100, `wave`=1, `busy`=1; `hit_ack` stays 0 with no requests.
- Req0 hits enemy 0 with dmg 30 → ack0 for 1 cycle, `enmhp1`=70. Repeat in the next cycle → acked, HP stays 70. Repeat after 9 cycles → `enmhp1`=40.
- All three requesters hold req continuously, pointer 0 → acks 0,1,2,0,1,2 in consecutive cycles.
- Enemy 2 at HP 15, dmg 40 → `enmhp3`=0. A further hit on enemy 2 is acked and HP stays 0.
- Kill all four enemies → `all_dead`=1 next cycle, CLEAR follows. Hits in CLEAR are acked with no effect. 64 cycles later HP = 100 ×4 and `wave`=2.
- Assert `rst` mid-RUN while ack0 is active → next cycle HP all 0, `wave` 0, IDLE. Held `hit_req` is then acked with no HP change.
